// File: rtl/abr_masked_mult_pkg.sv
// Shared types and helpers for the masked multiplier pipeline.
// Build option: define ABR_MASKED_MULT_REFRESH_EN to add the per-lane share refresh.
package abr_masked_mult_pkg;

   localparam int MAX_STAGES = 4;
   localparam int MAX_WIDTH  = 64;

   // Share pair held at the maximum supported width; narrower users zero-extend
   // and truncate back to their own WIDTH.
   typedef struct packed {
      logic [MAX_WIDTH-1:0] s1;
      logic [MAX_WIDTH-1:0] s0;
   } share_pair_t;

   // Recombines a share pair modulo 2^width. Only for observers (bench, checkers);
   // the datapath never recombines shares.
   function automatic logic [MAX_WIDTH-1:0] share_sum(input share_pair_t pair,
                                                      input int unsigned width);
      logic [MAX_WIDTH-1:0] sum_v;
      logic [MAX_WIDTH-1:0] mask_v;
      sum_v = pair.s0 + pair.s1;
      if (width >= MAX_WIDTH) begin
         mask_v = {MAX_WIDTH{1'b1}};
      end else begin
         mask_v = (64'd1 << width) - 64'd1;
      end
      return sum_v & mask_v;
   endfunction

endpackage

// File: rtl/abr_masked_mult_lane.sv
// One multiplier lane: multiplies each arithmetic share of x by the public y,
// truncated to WIDTH bits. With ABR_MASKED_MULT_REFRESH_EN the product shares
// are re-masked with fresh randomness (+r on share 0, -r on share 1).
module abr_masked_mult_lane
   import abr_masked_mult_pkg::*;
#(
   parameter int WIDTH   = 24,
   parameter int Y_WIDTH = 12
)
(
   input  logic [WIDTH-1:0]   x0,
   input  logic [WIDTH-1:0]   x1,
   input  logic [Y_WIDTH-1:0] y,
   input  logic [WIDTH-1:0]   rnd,
   output logic [WIDTH-1:0]   z0,
   output logic [WIDTH-1:0]   z1
);

   logic [WIDTH-1:0] y_ext_s;
   logic [WIDTH-1:0] p0_s;
   logic [WIDTH-1:0] p1_s;

   assign y_ext_s = WIDTH'(y);

   // Per-share products, evaluated in WIDTH bits so the result is already mod 2^WIDTH.
   always_comb begin
      p0_s = x0 * y_ext_s;
      p1_s = x1 * y_ext_s;
   end

`ifdef ABR_MASKED_MULT_REFRESH_EN
   // Re-mask the product shares; the share sum is unchanged.
   always_comb begin
      z0 = p0_s + rnd;
      z1 = p1_s - rnd;
   end
`else
   logic unused_rnd_s;
   assign unused_rnd_s = ^rnd;

   // Product shares pass straight through.
   always_comb begin
      z0 = p0_s;
      z1 = p1_s;
   end
`endif

endmodule

// File: rtl/abr_masked_mult_pipe.sv
// Elastic multi-lane pipeline of masked multipliers with valid/ready flow control,
// bubble collapsing and synchronous zeroize. Stage 1 captures the lane products;
// later stages are pure delay. Build option: ABR_MASKED_MULT_REFRESH_EN.
module abr_masked_mult_pipe
   import abr_masked_mult_pkg::*;
#(
   parameter int WIDTH   = 24,
   parameter int Y_WIDTH = 12,
   parameter int LANES   = 4,
   parameter int STAGES  = 2
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       zeroize,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [LANES*2*WIDTH-1:0]   x_i,
   input  logic [LANES*Y_WIDTH-1:0]   y_i,
   input  logic [LANES*WIDTH-1:0]     rnd_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [LANES*2*WIDTH-1:0]   z_o,
   output logic                       busy_o
);

   localparam int LW = 2 * WIDTH;
   localparam int DW = LANES * LW;

   logic [DW-1:0]     prod_s;
   logic [DW-1:0]     data_r   [STAGES];
   logic [DW-1:0]     up_data_s[STAGES];
   logic [STAGES-1:0] valid_r;
   logic [STAGES-1:0] up_valid_s;
   logic [STAGES-1:0] load_s;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      abr_masked_mult_lane #(
         .WIDTH   (WIDTH),
         .Y_WIDTH (Y_WIDTH)
      ) u_lane (
         .x0  (x_i[k*LW +: WIDTH]),
         .x1  (x_i[k*LW + WIDTH +: WIDTH]),
         .y   (y_i[k*Y_WIDTH +: Y_WIDTH]),
         .rnd (rnd_i[k*WIDTH +: WIDTH]),
         .z0  (prod_s[k*LW +: WIDTH]),
         .z1  (prod_s[k*LW + WIDTH +: WIDTH])
      );
   end

   // A stage may load when it, or any stage after it, is empty, or the output drains.
   always_comb begin : load_chain
      logic room_v;
      room_v = out_ready_i;
      load_s = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         room_v    = room_v || !valid_r[s];
         load_s[s] = room_v;
      end
   end

   // Upstream source of each stage: the lane products feed stage 1.
   always_comb begin
      up_valid_s    = '0;
      up_valid_s[0] = in_valid_i;
      up_data_s[0]  = prod_s;
      for (int s = 1; s < STAGES; s++) begin
         up_valid_s[s] = valid_r[s-1];
         up_data_s[s]  = data_r[s-1];
      end
   end

   // Stage registers: zeroize beats any handshake; data only moves with a valid beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_r[s] <= '0;
         end
      end else if (zeroize) begin
         valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_r[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (load_s[s]) begin
               valid_r[s] <= up_valid_s[s];
               if (up_valid_s[s]) begin
                  data_r[s] <= up_data_s[s];
               end
            end
         end
      end
   end

   assign in_ready_o  = load_s[0];
   assign out_valid_o = valid_r[STAGES-1];
   assign z_o         = data_r[STAGES-1];
   assign busy_o      = |valid_r;

endmodule

// File: doc/abr_masked_mult_pipe.md
Name: abr_masked_mult_pipe

Overview:
- Multi-lane, elastic pipelined multiplier on 2-share arithmetic-masked operands.
- Each lane computes z0 + z1 = (x0 + x1) * y mod 2^WIDTH. x is secret and masked; y is public and unmasked.
- Valid/ready handshake with back-pressure, per-stage zeroize, optional fresh-randomness share refresh.
- Serves as the masked-multiply datapath element for NTT/sampler pipelines that need stall tolerance.

Parameters:
- WIDTH, 24, bit width of each x share and each z share.
- Y_WIDTH, 12, bit width of public operand y per lane; 1 <= Y_WIDTH <= WIDTH.
- LANES, 4, number of independent parallel multiplier lanes.
- STAGES, 2, pipeline register stages; 1..4. Stage 1 holds the product; stages 2..STAGES are retiming/delay.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- zeroize  input  1  synchronous clear of all data and valid state
- in_valid_i  input  1  input transaction valid
- in_ready_o  output  1  block can accept an input this cycle
- x_i  input  LANES*2*WIDTH  per lane {x1, x0} arithmetic shares; lane k at bits [k*2*WIDTH +: 2*WIDTH]
- y_i  input  LANES*Y_WIDTH  per lane public operand
- rnd_i  input  LANES*WIDTH  fresh randomness, one word per lane; sampled on input handshake
- out_valid_o  output  1  output transaction valid
- out_ready_i  input  1  downstream accepts output
- z_o  output  LANES*2*WIDTH  per lane {z1, z0} arithmetic shares of the product
- busy_o  output  1  any pipeline stage holds valid data

Behaviour:
- Decided: reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: every stage valid bit = 0 and all data registers = 0. Hence out_valid_o = 0, z_o = 0, busy_o = 0, in_ready_o = 1.
- Arithmetic, per lane:
  - p0 = (x0 * y) mod 2^WIDTH and p1 = (x1 * y) mod 2^WIDTH.
  - Full product widths are truncated to WIDTH; there is no modular reduction beyond 2^WIDTH.
  - Shares are never recombined: x0+x1 and p0+p1 are never computed, and shares stay in separate registers.
- Pipeline:
  - STAGES register stages, each with its own valid bit v[s]. Stage s advances when v[s+1] == 0 or stage s+1 advances.
  - The last stage advances when out_ready_i == 1.
  - in_ready_o = !v[1] || adv[1]. This is combinational from out_ready_i through the chain; no skid buffer.
  - Input handshake: in_valid_i && in_ready_o. Stage 1 captures p0/p1 (plus refresh, see Optional Feature) and sets v[1] = 1.
  - Output handshake: out_valid_o && out_ready_i. Data leaves and the last-stage valid clears unless refilled the same cycle.
- Latency and throughput:
  - Without stalls, latency = STAGES cycles from input handshake to out_valid_o; throughput is 1 transaction/cycle.
- Stalls: a stalled stage holds its data and valid unchanged. Bubbles collapse, meaning an empty stage accepts from upstream even while downstream is stalled.
- Full/empty:
  - Full: all v = 1 and out_ready_i = 0, so in_ready_o = 0 and inputs are ignored.
  - Full with out_ready_i = 1: simultaneous accept and emit is allowed.
  - Empty: busy_o = 0.
- zeroize has priority over any handshake in the same cycle. Next cycle: all data = 0, all v = 0, and the input offered that cycle is dropped. in_ready_o remains combinational, i.e. 1 when empty.
- Reset mid-operation: all in-flight transactions are discarded with no output; outputs take reset values immediately (asynchronous).
- z_o holds its last value when out_valid_o = 0, except after zeroize or reset, when it reads 0.

Optional Feature:
- Macro: ABR_MASKED_MULT_REFRESH_EN.
- Defined: at stage 1, per lane, z0 = (p0 + r) mod 2^WIDTH and z1 = (p1 - r) mod 2^WIDTH, with r = rnd_i lane word. The unmasked sum is unchanged.
- Undefined: rnd_i is ignored, no refresh adders are generated, and z0 = p0, z1 = p1.
- The port list is identical in both builds.

Decomposition:
- Package abr_masked_mult_pkg:
  - localparam MAX_STAGES = 4.
  - typedef for the lane share pair: struct {logic [WIDTH-1:0] s0, s1}. Use a param-width helper or fixed-max width with truncation.
  - Function share_sum for testbench/assertion use only.
- Sub-module abr_masked_mult_lane: combinational per-lane share products and optional refresh, instantiated LANES times.
- Pipeline and valid/ready control live in the top.

Test Plan:
- WIDTH=24, STAGES=2, lane0: x0=0x000003, x1=0x000004, y=5, out_ready=1 -> out_valid 2 cycles after handshake; z0+z1 mod 2^24 = 0x000023.
- Wrap: x0=0xFFFFFF, x1=0x000002, y=0xFFF -> (z0+z1) mod 2^24 = 0x000FFF; each share equals its truncated individual product (refresh off).
- Back-pressure: out_ready=0, 3 consecutive inputs -> in_ready drops after STAGES accepted; release -> outputs emerge in order, no loss or duplication.
- Zeroize with pipeline full and in_valid=1 -> next cycle all v=0, z_o=0, busy_o=0; the offered input never appears at the output.
- Async reset asserted mid-stream -> out_valid_o=0 and z_o=0 immediately; after release in_ready_o=1.
- REFRESH_EN, rnd=0x123456, x0=1, x1=2, y=7 -> z0=0x12345D, z1=(0xE - 0x123456) mod 2^24 = 0xEDCBB8; sum = 0x000015.
